// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the shared ALU and its scheduler.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } share_state_e;

  function automatic logic op_supported(input logic [ALU_OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// One client channel of the shared-ALU scheduler: request handshake plus response handshake.
interface alu_share_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [WIDTH-1:0]    req_a;
  logic [WIDTH-1:0]    req_b;
  logic [ALU_OP_W-1:0] req_op;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_result;
  logic                rsp_zero;
  logic                rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu.sv
// Combinational shared ALU: ADD/SUB with wrap-around; zero flag reported for SUB only.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [WIDTH-1:0]    result,
  output logic                zero_flag
);

  always_comb begin
    result    = '0;
    zero_flag = 1'b0;
    case (op)
      OP_ADD: result = operand_a + operand_b;
      OP_SUB: begin
        result    = operand_a - operand_b;
        zero_flag = (operand_a == operand_b);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant advances only when the caller signals a transfer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt_c
);

  logic last_grant;

  // Reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= gnt_c[1];
    end
  end

  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Schedules two clients onto one combinational ALU: accept, execute for one cycle, hold response.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_ctrl_if.slave     port0,
  alu_share_ctrl_if.slave     port1,
  output logic [WIDTH-1:0]    alu_operand_a,
  output logic [WIDTH-1:0]    alu_operand_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_zero
);

  share_state_e state, state_nxt;

  logic [1:0]            req_vec, rsp_rdy, gnt_c, rdy_c;
  logic                  xfer_c;
  logic                  gidx;
  logic                  unsup_q;
  logic [1:0][WIDTH-1:0] res_q;
  logic [1:0]            zero_q, err_q, rsp_valid_q;
  logic [WIDTH-1:0]      win_a, win_b;
  logic [ALU_OP_W-1:0]   win_op;

  assign req_vec = {port1.req_valid, port0.req_valid};
  assign rsp_rdy = {port1.rsp_ready, port0.rsp_ready};
  assign win_a   = gnt_c[1] ? port1.req_a  : port0.req_a;
  assign win_b   = gnt_c[1] ? port1.req_b  : port0.req_b;
  assign win_op  = gnt_c[1] ? port1.req_op : port0.req_op;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .update (xfer_c),
    .gnt_c  (gnt_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy_c     = 2'b00;
    xfer_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst) rdy_c = gnt_c;
        xfer_c = |(rdy_c & req_vec);
        if (xfer_c) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_rdy[gidx]) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU inputs are loaded only for the single EXEC cycle of a supported op, else 0/0/ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_op        <= OP_ADD;
      gidx          <= 1'b0;
      unsup_q       <= 1'b0;
      res_q         <= '0;
      zero_q        <= 2'b00;
      err_q         <= 2'b00;
      rsp_valid_q   <= 2'b00;
    end else begin
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_op        <= OP_ADD;
      if (xfer_c) begin
        gidx    <= gnt_c[1];
        unsup_q <= !op_supported(win_op);
        if (op_supported(win_op)) begin
          alu_operand_a <= win_a;
          alu_operand_b <= win_b;
          alu_op        <= win_op;
        end
      end
      if (state == ST_EXEC) begin
        res_q[gidx]       <= unsup_q ? '0 : alu_result;
        zero_q[gidx]      <= !unsup_q && alu_zero;
        err_q[gidx]       <= unsup_q;
        rsp_valid_q[gidx] <= 1'b1;
      end
      if ((state == ST_RESP) && rsp_rdy[gidx]) begin
        rsp_valid_q[gidx] <= 1'b0;
      end
    end
  end

  assign port0.req_ready  = rdy_c[0];
  assign port1.req_ready  = rdy_c[1];
  assign port0.rsp_valid  = rsp_valid_q[0];
  assign port1.rsp_valid  = rsp_valid_q[1];
  assign port0.rsp_result = res_q[0];
  assign port1.rsp_result = res_q[1];
  assign port0.rsp_zero   = zero_q[0];
  assign port1.rsp_zero   = zero_q[1];
  assign port0.rsp_err    = err_q[0];
  assign port1.rsp_err    = err_q[1];

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with the shared alu: vector table plus stall, alternation and reset sequences.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WIDTH-1:0]    alu_a, alu_b, alu_res;
  logic [ALU_OP_W-1:0] alu_opc;
  logic                alu_z;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_last;

  alu_share_ctrl_if #(.WIDTH(WIDTH)) p0 ();
  alu_share_ctrl_if #(.WIDTH(WIDTH)) p1 ();

  alu #(.WIDTH(WIDTH)) u_alu (
    .operand_a (alu_a),
    .operand_b (alu_b),
    .op        (alu_opc),
    .result    (alu_res),
    .zero_flag (alu_z)
  );

  alu_share_ctrl #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .port0         (p0),
    .port1         (p1),
    .alu_operand_a (alu_a),
    .alu_operand_b (alu_b),
    .alu_op        (alu_opc),
    .alu_result    (alu_res),
    .alu_zero      (alu_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op);
    if (c) begin
      p1.req_valid = v; p1.req_a = a; p1.req_b = b; p1.req_op = op;
    end else begin
      p0.req_valid = v; p0.req_a = a; p0.req_b = b; p0.req_op = op;
    end
  endtask

  task automatic set_rsp_ready(input logic c, input logic r);
    if (c) p1.rsp_ready = r;
    else   p0.rsp_ready = r;
  endtask

  function automatic logic [1:0] readies();
    return {p1.req_ready, p0.req_ready};
  endfunction

  function automatic logic [1:0] rvalids();
    return {p1.rsp_valid, p0.rsp_valid};
  endfunction

  function automatic logic [31:0] res_of(input logic c);
    return c ? p1.rsp_result : p0.rsp_result;
  endfunction

  function automatic logic [1:0] flags_of(input logic c);
    return c ? {p1.rsp_zero, p1.rsp_err} : {p0.rsp_zero, p0.rsp_err};
  endfunction

  function automatic logic [1:0] onehot(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

  task automatic check_alu_idle(input string name);
    check(name, {alu_a[15:0], alu_b[11:0], alu_opc}, 32'h0);
    check({name, "_a"}, alu_a, 32'h0);
  endtask

  // Single request on an otherwise quiet bus; accept at T, EXEC at T+1, response from T+2.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.c, 1'b1, v.a, v.b, v.op);
    #1;
    check("vec_ready", 32'(readies()), 32'(onehot(v.c)));
    check_alu_idle("vec_alu_idle");
    @(negedge clk);
    drive(v.c, 1'b0, 32'h0, 32'h0, OP_ADD);
    #1;
    check("vec_exec_rvalid", 32'(rvalids()), 32'h0);
    check("vec_exec_a", alu_a, v.err ? 32'h0 : v.a);
    check("vec_exec_b", alu_b, v.err ? 32'h0 : v.b);
    check("vec_exec_op", 32'(alu_opc), v.err ? 32'h0 : 32'(v.op));
    @(negedge clk);
    #1;
    check("vec_resp_rvalid", 32'(rvalids()), 32'(onehot(v.c)));
    check("vec_resp_result", res_of(v.c), v.res);
    check("vec_resp_zero_err", 32'(flags_of(v.c)), 32'({v.zero, v.err}));
    check_alu_idle("vec_resp_alu");
    set_rsp_ready(v.c, 1'b1);
    @(negedge clk);
    #1;
    check("vec_done_rvalid", 32'(rvalids()), 32'h0);
    set_rsp_ready(v.c, 1'b0);
    exp_last = v.c;
  endtask

  initial begin
    p0.req_valid = 1'b0; p0.req_a = '0; p0.req_b = '0; p0.req_op = OP_ADD; p0.rsp_ready = 1'b0;
    p1.req_valid = 1'b0; p1.req_a = '0; p1.req_b = '0; p1.req_op = OP_ADD; p1.rsp_ready = 1'b0;

    tbl[0] = '{1'b0, 32'd5,        32'd7,        OP_ADD,  32'd12,       1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h1234,     32'h1234,     OP_SUB,  32'h0,        1'b1, 1'b0};
    tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'h1,        OP_ADD,  32'h0,        1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'd9,        32'd4,        4'b0101, 32'h0,        1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'd10,       32'd3,        OP_SUB,  32'd7,        1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'd3,        32'd10,       OP_SUB,  32'hFFFFFFF9, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'd0,        32'd0,        OP_ADD,  32'h0,        1'b0, 1'b0};

    // Reset state, with both requesters asserting valid to show ready is held low.
    drive(1'b0, 1'b1, 32'd1, 32'd1, OP_ADD);
    drive(1'b1, 1'b1, 32'd1, 32'd1, OP_ADD);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(readies()), 32'h0);
    check("rst_rvalid", 32'(rvalids()), 32'h0);
    check("rst_res0", res_of(1'b0), 32'h0);
    check("rst_res1", res_of(1'b1), 32'h0);
    check_alu_idle("rst_alu");
    drive(1'b0, 1'b0, 32'h0, 32'h0, OP_ADD);
    drive(1'b1, 1'b0, 32'h0, 32'h0, OP_ADD);
    rst = 1'b0;
    exp_last = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Held response on requester 1 stalls requester 0.
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h1234, 32'h1234, OP_SUB);
    #1;
    check("stall_ready1", 32'(readies()), 32'b10);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0, OP_ADD);
    drive(1'b0, 1'b1, 32'd1, 32'd1, OP_ADD);
    #1;
    check("stall_exec_ready", 32'(readies()), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("stall_rvalid", 32'(rvalids()), 32'b10);
      check("stall_result", res_of(1'b1), 32'h0);
      check("stall_zero_err", 32'(flags_of(1'b1)), 32'b10);
      check("stall_ready0", 32'(readies()), 32'h0);
    end
    p1.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("stall_release_rvalid", 32'(rvalids()), 32'h0);
    check("stall_release_ready0", 32'(readies()), 32'b01);
    p1.rsp_ready = 1'b0;
    p0.rsp_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, OP_ADD);
    @(negedge clk);
    #1;
    check("stall_p0_rvalid", 32'(rvalids()), 32'b01);
    check("stall_p0_result", res_of(1'b0), 32'd2);
    @(negedge clk);
    p0.rsp_ready = 1'b0;
    exp_last = 1'b0;

    // Both valid continuously: strict alternation, responses routed per client.
    drive(1'b0, 1'b1, 32'd1, 32'd2, OP_ADD);
    drive(1'b1, 1'b1, 32'h10, 32'h20, OP_ADD);
    p0.rsp_ready = 1'b1;
    p1.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic w;
      w = ~exp_last;
      #1;
      check("alt_grant", 32'(readies()), 32'(onehot(w)));
      @(negedge clk);
      #1;
      check("alt_exec_ready", 32'(readies()), 32'h0);
      @(negedge clk);
      #1;
      check("alt_rvalid", 32'(rvalids()), 32'(onehot(w)));
      check("alt_result", res_of(w), w ? 32'h30 : 32'd3);
      exp_last = w;
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, OP_ADD);
    drive(1'b1, 1'b0, 32'h0, 32'h0, OP_ADD);
    p0.rsp_ready = 1'b0;
    p1.rsp_ready = 1'b0;

    // Reset during EXEC of a SUB from requester 0 drops it and restores the tie-break.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'd9, 32'd9, OP_SUB);
    #1;
    check("rx_ready0", 32'(readies()), 32'b01);
    @(negedge clk);
    #1;
    check("rx_exec_op", 32'(alu_opc), 32'(OP_SUB));
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'd1, 32'd1, OP_ADD);
    drive(1'b1, 1'b1, 32'd5, 32'd5, OP_ADD);
    #1;
    check("rx_ready_in_rst", 32'(readies()), 32'h0);
    @(negedge clk);
    #1;
    check("rx_rvalid", 32'(rvalids()), 32'h0);
    check("rx_res0", res_of(1'b0), 32'h0);
    check("rx_res1", res_of(1'b1), 32'h0);
    check("rx_flags0", 32'(flags_of(1'b0)), 32'h0);
    check_alu_idle("rx_alu");
    rst = 1'b0;
    #1;
    check("rx_tie_p0", 32'(readies()), 32'b01);
    p0.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rx_p0_rvalid", 32'(rvalids()), 32'b01);
    check("rx_p0_result", res_of(1'b0), 32'd2);
    drive(1'b0, 1'b0, 32'h0, 32'h0, OP_ADD);
    drive(1'b1, 1'b0, 32'h0, 32'h0, OP_ADD);
    @(negedge clk);
    p0.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
